bytewrite_tdp_ram_cfg: RTL and testbench
========================================

BYTEWRITE_TDP_RAM_CFG -- requirements
Module: bytewrite_tdp_ram_cfg

Interface
REQ-001 The block SHALL have these parameters: NUM_COL, default 4, byte-enable columns per word.
REQ-002 COL_WIDTH, default 8, bits per column.
REQ-003 ADDR_WIDTH, default 10, address bits; depth = 2**ADDR_WIDTH.
REQ-004 DATA_WIDTH, default NUM_COL*COL_WIDTH, word width; other values are illegal.
REQ-005 READ_MODE, default 0, per-port read behaviour: 0 read-first, 1 write-first, 2 no-change; 3 is illegal.
REQ-006 OUT_REG, default 0, extra output register stage: 0 or 1.
REQ-007 clk  input  1  single clock for both ports; all logic is on its rising edge.
REQ-008 rst_n  input  1  reset, synchronous and active-low.
REQ-009 enaA, enaB  input  1  port enable.
REQ-010 weA, weB  input  NUM_COL  per-column write enable, qualified by ena.
REQ-011 addrA, addrB  input  ADDR_WIDTH  word address.
REQ-012 dinA, dinB  input  DATA_WIDTH  write data.
REQ-013 doutA, doutB  output  DATA_WIDTH  registered read data.
REQ-014 validA, validB  output  1  dout updated this cycle.
REQ-015 collision  output  1  single-cycle address-collision pulse.
REQ-016 collision_cnt  output  16  saturating collision count.

Function
REQ-017 An access SHALL occur on port X in a cycle when enaX=1; when enaX=0, port X SHALL neither read nor write.
REQ-018 Each column i with weX[i]=1 SHALL write dinX[i*COL_WIDTH +: COL_WIDTH] to the same columns of word addrX; the other columns SHALL be unchanged.
REQ-019 Read latency SHALL be 1+OUT_REG cycles from the access edge to the dout/valid update.
REQ-020 READ_MODE=0: dout SHALL present the word as it was before this edge's write.
REQ-021 READ_MODE=1: dout SHALL present the word after this edge's write by the same port, per column.
REQ-022 READ_MODE=2: an access with any weX bit set SHALL leave doutX and validX unchanged (validX=0); a pure read SHALL update as in mode 0.
REQ-023 validX SHALL be 1 exactly in the cycles where doutX takes a new value; otherwise it SHALL be 0 and doutX SHALL hold.
REQ-024 Collision SHALL be defined as: enaA=1, enaB=1, addrA==addrB, and (weA|weB)!=0, all in the same cycle.
REQ-025 Write-write collision: for columns written by both ports, port B's data SHALL win; disjoint columns SHALL both be written.
REQ-026 Cross-port read during a collision: each port SHALL read the pre-edge word for columns written by the other port, in every READ_MODE.
REQ-027 When OUT_REG=1, the pipeline stage SHALL advance every cycle; dout and valid SHALL be delayed as a pair.
REQ-028 Addresses SHALL have no wrap or out-of-range case; all 2**ADDR_WIDTH words are addressable.

Reset
REQ-029 While rst_n=0 at an edge: doutA, doutB, validA, validB, collision, collision_cnt and all pipeline registers SHALL be 0, and no memory write SHALL occur.
REQ-030 Memory contents SHALL NOT be reset; they SHALL be retained across reset.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight reads; no valid SHALL appear for accesses made before or during reset.
REQ-032 The first access after rst_n rises SHALL respond after the normal latency.

Configuration
REQ-033 With macro BYTEWRITE_TDP_COLLISION_EN defined, collision SHALL pulse high for 1+OUT_REG-aligned cycles (one cycle, in the dout-update cycle of the colliding access), and collision_cnt SHALL increment per collision, saturating at 16'hFFFF.
REQ-034 Without BYTEWRITE_TDP_COLLISION_EN, collision and collision_cnt SHALL be constant 0, no detection logic SHALL be present, and the REQ-025/026 data behaviour SHALL be unchanged.

Verification
REQ-035 Mode 0, OUT_REG=0: write A addr 5 = 32'h11223344, then A write weA=4'b0010, dinA=32'hAABBCCDD, then read -> dout at 2nd access = 32'h11223344; at 3rd = 32'h1122CC44.
REQ-036 Mode 1, OUT_REG=1: A write weA=4'hF, data 32'hDEADBEEF to addr 0 -> validA and doutA=32'hDEADBEEF two cycles later.
REQ-037 Mode 2: A write to addr 7 with doutA=32'h0000_0001 held -> validA=0 and doutA unchanged; next pure read -> new data with validA=1.
REQ-038 Collision, macro on: same cycle, A weA=4'hF 32'h01010101 and B weB=4'h3 32'h02020202 at addr 9 -> memory 32'h01010202, collision=1 for one cycle, collision_cnt=1; B read returns the old word.
REQ-039 Reset mid-read with OUT_REG=1: assert rst_n=0 one cycle after a read -> no validA ever appears for it, all outputs 0, and memory is retained on the post-reset read.
REQ-040 Saturation: force 65536 collisions -> collision_cnt=16'hFFFF, stays there.

Source files
------------

// File: rtl/bytewrite_tdp_ram_cfg.sv
// Byte-write true dual-port RAM on one clock, configurable read mode and output register.
// Optional collision detection/counting is enabled by defining BYTEWRITE_TDP_COLLISION_EN.
`timescale 1ns/1ps
module bytewrite_tdp_ram_cfg #(
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int unsigned READ_MODE  = 0,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enaA,
  input  logic                  enaB,
  input  logic [NUM_COL-1:0]    weA,
  input  logic [NUM_COL-1:0]    weB,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dinA,
  input  logic [DATA_WIDTH-1:0] dinB,
  output logic [DATA_WIDTH-1:0] doutA,
  output logic [DATA_WIDTH-1:0] doutB,
  output logic                  validA,
  output logic                  validB,
  output logic                  collision,
  output logic [15:0]           collision_cnt
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [DATA_WIDTH-1:0] w_oldA, w_oldB;
  logic [DATA_WIDTH-1:0] w_rdA, w_rdB;
  logic                  w_same;
  logic                  w_updA, w_updB;
  logic [DATA_WIDTH-1:0] r_doutA1, r_doutB1;
  logic                  r_valA1, r_valB1;

  assign w_oldA = r_mem[addrA];
  assign w_oldB = r_mem[addrB];
  assign w_same = enaA & enaB & (addrA == addrB);

  // No-change mode suppresses the read of any access that writes.
  assign w_updA = enaA & ~((READ_MODE == 2) & (|weA));
  assign w_updB = enaB & ~((READ_MODE == 2) & (|weB));

  // Read data: pre-edge word, with own-port write data forwarded in write-first mode
  // except for columns the other port writes at the same address.
  always_comb begin
    w_rdA = w_oldA;
    w_rdB = w_oldB;
    if (READ_MODE == 1) begin
      for (int unsigned c = 0; c < NUM_COL; c++) begin
        if (weA[c] && !(w_same && weB[c]))
          w_rdA[c*COL_WIDTH +: COL_WIDTH] = dinA[c*COL_WIDTH +: COL_WIDTH];
        if (weB[c] && !(w_same && weA[c]))
          w_rdB[c*COL_WIDTH +: COL_WIDTH] = dinB[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // Column writes; port B is applied last so it wins on shared columns. Blocked in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned c = 0; c < NUM_COL; c++) begin
        if (enaA && weA[c])
          r_mem[addrA][c*COL_WIDTH +: COL_WIDTH] <= dinA[c*COL_WIDTH +: COL_WIDTH];
      end
      for (int unsigned c = 0; c < NUM_COL; c++) begin
        if (enaB && weB[c])
          r_mem[addrB][c*COL_WIDTH +: COL_WIDTH] <= dinB[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // First read stage: data loads only on an update, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_doutA1 <= '0;
      r_doutB1 <= '0;
      r_valA1  <= 1'b0;
      r_valB1  <= 1'b0;
    end else begin
      r_valA1 <= w_updA;
      r_valB1 <= w_updB;
      if (w_updA) r_doutA1 <= w_rdA;
      if (w_updB) r_doutB1 <= w_rdB;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_doutA2, r_doutB2;
      logic                  r_valA2, r_valB2;

      // Output stage advances every cycle, carrying data and valid together.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_doutA2 <= '0;
          r_doutB2 <= '0;
          r_valA2  <= 1'b0;
          r_valB2  <= 1'b0;
        end else begin
          r_doutA2 <= r_doutA1;
          r_doutB2 <= r_doutB1;
          r_valA2  <= r_valA1;
          r_valB2  <= r_valB1;
        end
      end

      assign doutA  = r_doutA2;
      assign doutB  = r_doutB2;
      assign validA = r_valA2;
      assign validB = r_valB2;
    end else begin : g_noreg
      assign doutA  = r_doutA1;
      assign doutB  = r_doutB1;
      assign validA = r_valA1;
      assign validB = r_valB1;
    end
  endgenerate

`ifdef BYTEWRITE_TDP_COLLISION_EN
  logic        w_col;
  logic        w_col_in;
  logic        r_col;
  logic [15:0] r_cnt;

  assign w_col = w_same & (|(weA | weB));

  generate
    if (OUT_REG != 0) begin : g_col_pipe
      logic r_col1;

      // Delay the detect by one stage to line up with the registered read data.
      always_ff @(posedge clk) begin
        if (!rst_n) r_col1 <= 1'b0;
        else        r_col1 <= w_col;
      end

      assign w_col_in = r_col1;
    end else begin : g_col_direct
      assign w_col_in = w_col;
    end
  endgenerate

  // Collision pulse and saturating count update together in the dout-update cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_col <= w_col_in;
      if (w_col_in && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
    end
  end

  assign collision     = r_col;
  assign collision_cnt = r_cnt;
`else
  assign collision     = 1'b0;
  assign collision_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bytewrite_tdp_ram_cfg.sv
// Scoreboard bench: three instances (read-first/no reg, write-first/out reg, no-change/no reg).
`timescale 1ns/1ps
module tb_bytewrite_tdp_ram_cfg;

  typedef struct {
    int          cyc;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cycle = 0;
  int          n_chk = 0;
  int          n_err = 0;

  logic        enaA_s [3];
  logic        enaB_s [3];
  logic [3:0]  weA_s  [3];
  logic [3:0]  weB_s  [3];
  logic [9:0]  addrA_s[3];
  logic [9:0]  addrB_s[3];
  logic [31:0] dinA_s [3];
  logic [31:0] dinB_s [3];
  logic [31:0] doutA_w[3];
  logic [31:0] doutB_w[3];
  logic        validA_w[3];
  logic        validB_w[3];
  logic        coll_w [3];
  logic [15:0] cnt_w  [3];

  // ids 0..5: inst*2+port (A=0,B=1); ids 6..8: collision of inst id-6
  exp_t exp_q [9][$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned RM = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int unsigned OR = (g == 1) ? 1 : 0;
    bytewrite_tdp_ram_cfg #(
      .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(10), .DATA_WIDTH(32),
      .READ_MODE(RM), .OUT_REG(OR)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .enaA(enaA_s[g]), .enaB(enaB_s[g]),
      .weA(weA_s[g]), .weB(weB_s[g]),
      .addrA(addrA_s[g]), .addrB(addrB_s[g]),
      .dinA(dinA_s[g]), .dinB(dinB_s[g]),
      .doutA(doutA_w[g]), .doutB(doutB_w[g]),
      .validA(validA_w[g]), .validB(validB_w[g]),
      .collision(coll_w[g]), .collision_cnt(cnt_w[g])
    );
  end

  function automatic int lat_of(input int inst);
    return (inst == 1) ? 1 : 0;
  endfunction

  task automatic clear_in();
    for (int i = 0; i < 3; i++) begin
      enaA_s[i] = 1'b0; enaB_s[i] = 1'b0;
      weA_s[i] = 4'h0;  weB_s[i] = 4'h0;
      addrA_s[i] = 10'd0; addrB_s[i] = 10'd0;
      dinA_s[i] = 32'h0;  dinB_s[i] = 32'h0;
    end
  endtask

  task automatic set_a(input int i, input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
    enaA_s[i] = 1'b1; weA_s[i] = we; addrA_s[i] = a; dinA_s[i] = d;
  endtask

  task automatic set_b(input int i, input logic [3:0] we, input logic [9:0] a, input logic [31:0] d);
    enaB_s[i] = 1'b1; weB_s[i] = we; addrB_s[i] = a; dinB_s[i] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  // Expected dout for the access issued before the next edge.
  task automatic exp_out(input int id, input bit chk, input logic [31:0] d);
    exp_t e;
    e.cyc = cycle + 1 + lat_of(id / 2); e.chk = chk; e.data = d;
    exp_q[id].push_back(e);
  endtask

  task automatic exp_col(input int inst, input logic [15:0] cnt);
`ifdef BYTEWRITE_TDP_COLLISION_EN
    exp_t e;
    e.cyc = cycle + 1 + lat_of(inst); e.chk = 1'b1; e.data = {16'h0, cnt};
    exp_q[6 + inst].push_back(e);
`else
    if (cnt == 16'hFFFF) $display("note: collision logic not built (inst %0d)", inst);
`endif
  endtask

  task automatic check_out(input int id, input logic v, input logic [31:0] d);
    exp_t e;
    if (v) begin
      n_chk++;
      if (exp_q[id].size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out id=%0d cyc=%0d got=%h (nothing expected)", id, cycle, d);
      end else begin
        e = exp_q[id].pop_front();
        if (e.cyc != cycle || (e.chk && d !== e.data)) begin
          n_err++;
          $display("FAIL out id=%0d got cyc=%0d data=%h expected cyc=%0d data=%h",
                   id, cycle, d, e.cyc, e.data);
        end
      end
    end
  endtask

  // Monitor: every output event is matched against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check_out(2 * i,     validA_w[i], doutA_w[i]);
      check_out(2 * i + 1, validB_w[i], doutB_w[i]);
      check_out(6 + i,     coll_w[i],   {16'h0, cnt_w[i]});
    end
  end

  task automatic check_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({doutA_w[i], doutB_w[i], validA_w[i], validB_w[i], coll_w[i], cnt_w[i]} !== 84'h0) begin
        n_err++;
        $display("FAIL %s inst=%0d got A=%h B=%h vA=%b vB=%b col=%b cnt=%h required all 0",
                 name, i, doutA_w[i], doutB_w[i], validA_w[i], validB_w[i], coll_w[i], cnt_w[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clear_in();
    repeat (3) step();
    check_zero("reset_outputs");
    rst_n = 1'b1;
    step();

    // Read-first partial write on inst 0.
    set_a(0, 4'hF, 10'd5, 32'h11223344); exp_out(0, 0, 32'h0); step();
    set_a(0, 4'b0010, 10'd5, 32'hAABBCCDD); exp_out(0, 1, 32'h11223344); step();
    set_a(0, 4'h0, 10'd5, 32'h0); exp_out(0, 1, 32'h1122CC44);
    set_b(0, 4'h0, 10'd5, 32'h0); exp_out(1, 1, 32'h1122CC44); step();

    // Collision on inst 0: B wins shared columns, both ports read the old word.
    set_a(0, 4'hF, 10'd9, 32'h55667788); exp_out(0, 0, 32'h0); step();
    set_a(0, 4'hF, 10'd9, 32'h01010101); exp_out(0, 1, 32'h55667788);
    set_b(0, 4'h3, 10'd9, 32'h02020202); exp_out(1, 1, 32'h55667788);
    exp_col(0, 16'd1); step();
    set_a(0, 4'h0, 10'd9, 32'h0); exp_out(0, 1, 32'h01010202); step();

    // Write-first with output register on inst 1.
    set_b(1, 4'hF, 10'd3, 32'h00000000); exp_out(3, 1, 32'h00000000); step();
    set_b(1, 4'b0101, 10'd3, 32'h12345678); exp_out(3, 1, 32'h00340078); step();
    set_a(1, 4'hF, 10'd9, 32'hA5A5A5A5); exp_out(2, 1, 32'hA5A5A5A5); step();
    set_a(1, 4'hF, 10'd9, 32'h01010101); exp_out(2, 1, 32'h0101A5A5);
    set_b(1, 4'h3, 10'd9, 32'h02020202); exp_out(3, 1, 32'hA5A5A5A5);
    exp_col(1, 16'd1); step();
    set_a(1, 4'h0, 10'd9, 32'h0); exp_out(2, 1, 32'h01010202); step();
    set_a(1, 4'hF, 10'd0, 32'hDEADBEEF); exp_out(2, 1, 32'hDEADBEEF); step();
    step();

    // No-change mode on inst 2: writes leave dout/valid alone.
    set_a(2, 4'hF, 10'd6, 32'h00000001); step();
    set_a(2, 4'h0, 10'd6, 32'h0); exp_out(4, 1, 32'h00000001); step();
    set_a(2, 4'hF, 10'd7, 32'hCAFEF00D); set_b(2, 4'h1, 10'd8, 32'h000000EE); step();
    n_chk++;
    if (doutA_w[2] !== 32'h00000001 || validA_w[2] !== 1'b0) begin
      n_err++;
      $display("FAIL nochange_hold got dout=%h valid=%b required dout=00000001 valid=0",
               doutA_w[2], validA_w[2]);
    end
    set_a(2, 4'h0, 10'd7, 32'h0); exp_out(4, 1, 32'hCAFEF00D); step();

    // Reset one cycle after a registered read; a write issued in reset must be dropped.
    set_a(1, 4'h0, 10'd0, 32'h0); step();
    rst_n = 1'b0;
    set_a(0, 4'hF, 10'd5, 32'hFFFFFFFF);
    step();
    step();
    check_zero("midreset_outputs");
    rst_n = 1'b1;
    step();
    set_a(1, 4'h0, 10'd0, 32'h0); exp_out(2, 1, 32'hDEADBEEF);
    set_a(0, 4'h0, 10'd5, 32'h0); exp_out(0, 1, 32'h1122CC44); step();
    repeat (3) step();

`ifdef BYTEWRITE_TDP_COLLISION_EN
    // Saturation: count restarted at reset, 65536 collisions must pin it at FFFF.
    for (int k = 1; k <= 65536; k++) begin
      set_a(0, 4'hF, 10'd9, 32'h01010101); exp_out(0, 1, 32'h01010202);
      set_b(0, 4'h3, 10'd9, 32'h02020202); exp_out(1, 1, 32'h01010202);
      exp_col(0, (k >= 65535) ? 16'hFFFF : 16'(k));
      step();
    end
    repeat (3) step();
    n_chk++;
    if (cnt_w[0] !== 16'hFFFF) begin
      n_err++;
      $display("FAIL saturation got cnt=%h required FFFF", cnt_w[0]);
    end
`else
    set_a(0, 4'hF, 10'd9, 32'h01010101); exp_out(0, 1, 32'h01010202);
    set_b(0, 4'h3, 10'd9, 32'h02020202); exp_out(1, 1, 32'h01010202);
    step();
    repeat (3) step();
    n_chk++;
    if (cnt_w[0] !== 16'h0 || coll_w[0] !== 1'b0) begin
      n_err++;
      $display("FAIL collision_off got cnt=%h col=%b required 0", cnt_w[0], coll_w[0]);
    end
`endif

    for (int id = 0; id < 9; id++) begin
      n_chk++;
      if (exp_q[id].size() != 0) begin
        n_err++;
        $display("FAIL missing_out id=%0d got %0d pending required 0", id, exp_q[id].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
